bp_cce_mode_switch_ctrl: RTL and testbench
==========================================

Name: bp_cce_mode_switch_ctrl

Overview:
- Sequences CCE mode transitions between uncached and normal (cached) operation.
- Tracks outstanding memory commands from the message unit and gates new LCE request acceptance while a switch is pending.
- Commits the new mode only after the memory channel has drained, and exports the committed mode that steers the cached/uncached message-path mux.
- Also issues memory-command credits, capping the number of outstanding memory commands.

Parameters:
- max_outstanding_p, 4: maximum in-flight memory commands (>=1).
- reset_mode_p, 0: committed mode after reset (0 = uncached, 1 = normal).
- cnt_width_lp, derived = `BSG_SAFE_CLOG2(max_outstanding_p+1)`: width of the outstanding counter.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- mode_req_i  in  1  requested mode from cfg bus (0 uncached, 1 normal)
- mem_cmd_v_i  in  1  mem_cmd valid from message path
- mem_cmd_ready_i  in  1  mem_cmd ready from memory side
- mem_resp_v_i  in  1  mem_resp valid from memory side
- mem_resp_yumi_i  in  1  mem_resp yumi from message path
- mode_o  out  1  committed mode (mux select)
- lce_req_gate_o  out  1  1 = message path must not accept new LCE requests
- mem_cmd_credit_o  out  1  1 = message path may issue a memory command
- switch_busy_o  out  1  switch in progress
- switch_done_o  out  1  one-cycle pulse when a new mode commits
- outstanding_o  out  cnt_width_lp  current in-flight memory commands
- error_o  out  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: the block uses one clock, clk_i. Reset is asynchronous and active-low on reset_n_i.
- Reset values:
  - state = RUN
  - mode_o = reset_mode_p
  - target = reset_mode_p
  - outstanding_o = 0
  - error_o = 0
  - switch_done_o = 0
  - lce_req_gate_o = 0
  - switch_busy_o = 0
  - mem_cmd_credit_o = 1
- Events:
  - inc = mem_cmd_v_i & mem_cmd_ready_i
  - dec = mem_resp_v_i & mem_resp_yumi_i
- Counter update each cycle:
  - inc & ~dec: +1
  - dec & ~inc: -1
  - both or neither: unchanged
- Counter violations:
  - inc at max_outstanding_p with no dec: counter saturates at max; error_o set.
  - dec at 0 with no inc: counter stays 0; error_o set.
  - error_o clears only on reset.
- State RUN:
  - lce_req_gate_o = 0, switch_busy_o = 0.
  - mem_cmd_credit_o = (outstanding_o < max_outstanding_p).
  - If mode_req_i != mode_o: target <= mode_req_i; next state DRAIN.
  - Commands handshaken in the detection cycle are counted normally.
- State DRAIN:
  - lce_req_gate_o = 1, switch_busy_o = 1, mem_cmd_credit_o = 0.
  - target stays frozen; changes on mode_req_i are ignored.
  - Next state is SWITCH when the next-cycle counter value is 0 (i.e. outstanding_o == 0 with no inc, or outstanding_o == 1 with dec and no inc).
  - An inc while in DRAIN (credit ignored) is counted, not flagged, and extends the drain.
- State SWITCH (exactly 1 cycle):
  - lce_req_gate_o = 1, switch_busy_o = 1, mem_cmd_credit_o = 0, switch_done_o = 1.
  - mode_o <= target at the end of this cycle; next state RUN.
- Latency:
  - Minimum, with an empty channel: mismatch seen in cycle t; DRAIN in t+1; SWITCH in t+2; new mode_o visible in t+3.
  - Gate is high during t+1..t+2.
- Request reverted during a switch: if mode_req_i flips back during DRAIN, the switch to the latched target still completes. RUN then detects the new mismatch and starts another switch.
- Output timing:
  - lce_req_gate_o, switch_busy_o, switch_done_o and mode_o are functions of registered state only.
  - mem_cmd_credit_o depends only on state and the registered counter.
  - No combinational path from any input to any output.
- Asynchronous reset during DRAIN or SWITCH: immediate return to reset values; mode_o reverts to reset_mode_p; no switch_done_o pulse.

Test Plan:
- Reset with reset_mode_p=0 and mode_req_i=0: mode_o=0, credit=1, gate=0, outstanding_o=0 -> stays idle for 10 cycles, no done pulse.
- Empty-channel switch: mode_req_i 0->1 at cycle 5 -> gate=1 in cycles 6-7, switch_done_o=1 in cycle 7 only, mode_o=1 from cycle 8, gate=0 from cycle 8.
- Drain with traffic: issue 3 commands (outstanding_o=3), then raise mode_req_i=1 -> credit=0 and DRAIN holds. Return responses at cycles +4, +6, +9 -> SWITCH the cycle after the third dec; mode_o=1 one cycle later.
- Credit limit (max=4): 4 inc handshakes -> credit=0 at count 4. Simultaneous inc+dec -> count stays 4, error_o=0. A fifth inc with no dec -> count 4, error_o=1.
- Request reverted mid-drain: outstanding=2, mode_req_i 0->1, then back to 0 after 1 cycle. Responses drain -> mode_o commits to 1, then a second switch commits mode_o=0; two done pulses.
- Asynchronous reset asserted in DRAIN with outstanding=2 -> immediately mode_o=reset_mode_p, outstanding_o=0, gate=0, error_o=0, no done pulse.

Source files
------------

// File: rtl/bp_cce_mode_switch_ctrl_if.sv
// Bundle of the cfg, memory-channel handshake and status signals of the
// CCE mode-switch controller. The slave modport is the controller's view;
// the master modport is the view of whatever drives it.
interface bp_cce_mode_switch_ctrl_if #(
    parameter int max_outstanding_p = 4,
    parameter int cnt_width_lp      = ($clog2(max_outstanding_p + 1) < 1) ? 1
                                      : $clog2(max_outstanding_p + 1)
);
    logic                    mode_req_i;
    logic                    mem_cmd_v_i;
    logic                    mem_cmd_ready_i;
    logic                    mem_resp_v_i;
    logic                    mem_resp_yumi_i;
    logic                    mode_o;
    logic                    lce_req_gate_o;
    logic                    mem_cmd_credit_o;
    logic                    switch_busy_o;
    logic                    switch_done_o;
    logic [cnt_width_lp-1:0] outstanding_o;
    logic                    error_o;

    modport slave (
        input  mode_req_i, mem_cmd_v_i, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_i,
        output mode_o, lce_req_gate_o, mem_cmd_credit_o, switch_busy_o,
               switch_done_o, outstanding_o, error_o
    );

    modport master (
        output mode_req_i, mem_cmd_v_i, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_i,
        input  mode_o, lce_req_gate_o, mem_cmd_credit_o, switch_busy_o,
               switch_done_o, outstanding_o, error_o
    );
endinterface

// File: rtl/bp_cce_mode_switch_ctrl.sv
// CCE mode-switch controller: counts in-flight memory commands, issues
// command credits, and moves the committed cached/uncached mode only after
// the memory channel has drained. LCE requests are gated for the whole
// switch. All outputs come from registered state.
module bp_cce_mode_switch_ctrl #(
    parameter int max_outstanding_p = 4,
    parameter bit reset_mode_p      = 1'b0,
    localparam int cnt_width_lp     = ($clog2(max_outstanding_p + 1) < 1) ? 1
                                      : $clog2(max_outstanding_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    bp_cce_mode_switch_ctrl_if.slave       bus
);
    localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_outstanding_p);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_e;

    state_e                  state_r, state_n;
    logic                    mode_r, mode_n;
    logic                    target_r, target_n;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
    logic                    error_r;
    logic                    viol;
    logic                    inc, dec;

    assign inc = bus.mem_cmd_v_i & bus.mem_cmd_ready_i;
    assign dec = bus.mem_resp_v_i & bus.mem_resp_yumi_i;

    // Next outstanding count; over/underflow saturates and raises a violation.
    always_comb begin
        cnt_n = cnt_r;
        viol  = 1'b0;
        if (inc && !dec) begin
            if (cnt_r == max_cnt_lp) viol  = 1'b1;
            else                     cnt_n = cnt_r + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_r == '0) viol  = 1'b1;
            else             cnt_n = cnt_r - 1'b1;
        end
    end

    // Switch sequencing and status outputs derived from the registered state.
    always_comb begin
        state_n              = state_r;
        target_n             = target_r;
        mode_n               = mode_r;
        bus.lce_req_gate_o   = 1'b1;
        bus.switch_busy_o    = 1'b1;
        bus.switch_done_o    = 1'b0;
        bus.mem_cmd_credit_o = 1'b0;
        case (state_r)
            RUN: begin
                bus.lce_req_gate_o   = 1'b0;
                bus.switch_busy_o    = 1'b0;
                bus.mem_cmd_credit_o = (cnt_r < max_cnt_lp);
                if (bus.mode_req_i != mode_r) begin
                    target_n = bus.mode_req_i;
                    state_n  = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_n == '0) state_n = SWITCH;
            end
            SWITCH: begin
                bus.switch_done_o = 1'b1;
                mode_n            = target_r;
                state_n           = RUN;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // State, mode, counter and sticky error registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= RUN;
            mode_r   <= reset_mode_p;
            target_r <= reset_mode_p;
            cnt_r    <= '0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_n;
            mode_r   <= mode_n;
            target_r <= target_n;
            cnt_r    <= cnt_n;
            error_r  <= error_r | viol;
        end
    end

    assign bus.mode_o        = mode_r;
    assign bus.outstanding_o = cnt_r;
    assign bus.error_o       = error_r;
endmodule

// File: tb/tb_bp_cce_mode_switch_ctrl.sv
// Directed bench for bp_cce_mode_switch_ctrl (max_outstanding_p=4,
// reset_mode_p=0). Inputs change 1 time unit after each rising edge and
// outputs are checked at that same point, well clear of the next edge.
module tb_bp_cce_mode_switch_ctrl;
    logic clk_i;
    logic reset_n_i;
    int   total;
    int   bad;

    bp_cce_mode_switch_ctrl_if #(.max_outstanding_p(4)) bus ();

    bp_cce_mode_switch_ctrl #(
        .max_outstanding_p(4),
        .reset_mode_p(1'b0)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .bus(bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        bus.mem_cmd_v_i     = 1'b0;
        bus.mem_cmd_ready_i = 1'b1;
        bus.mem_resp_v_i    = 1'b0;
        bus.mem_resp_yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        bus.mode_req_i = 1'b0;
        set_idle();
        #2;
        total++; if (bus.mode_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_mode: got %b expected 0", bus.mode_o); end
        total++; if (bus.mem_cmd_credit_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_credit: got %b expected 1", bus.mem_cmd_credit_o); end
        total++; if (bus.lce_req_gate_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_gate: got %b expected 0", bus.lce_req_gate_o); end
        total++; if (bus.outstanding_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", bus.outstanding_o); end
        total++; if (bus.error_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %b expected 0", bus.error_o); end
        total++; if (bus.switch_busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.switch_busy_o); end
        total++; if (bus.switch_done_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", bus.switch_done_o); end
        tick();
        reset_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (bus.switch_done_o !== 1'b0 || bus.lce_req_gate_o !== 1'b0 || bus.mode_o !== 1'b0)
                begin bad++; $display("[TB] FAIL idle_cycle%0d: got done=%b gate=%b mode=%b expected 0/0/0", i, bus.switch_done_o, bus.lce_req_gate_o, bus.mode_o); end
        end
    endtask

    task automatic test_empty_switch();
        bus.mode_req_i = 1'b1;
        tick();
        total++; if (bus.lce_req_gate_o !== 1'b1 || bus.switch_done_o !== 1'b0 || bus.mode_o !== 1'b0 || bus.mem_cmd_credit_o !== 1'b0)
            begin bad++; $display("[TB] FAIL empty_drain: got gate=%b done=%b mode=%b credit=%b expected 1/0/0/0", bus.lce_req_gate_o, bus.switch_done_o, bus.mode_o, bus.mem_cmd_credit_o); end
        tick();
        total++; if (bus.lce_req_gate_o !== 1'b1 || bus.switch_done_o !== 1'b1 || bus.mode_o !== 1'b0)
            begin bad++; $display("[TB] FAIL empty_switch: got gate=%b done=%b mode=%b expected 1/1/0", bus.lce_req_gate_o, bus.switch_done_o, bus.mode_o); end
        tick();
        total++; if (bus.lce_req_gate_o !== 1'b0 || bus.switch_done_o !== 1'b0 || bus.mode_o !== 1'b1 || bus.mem_cmd_credit_o !== 1'b1)
            begin bad++; $display("[TB] FAIL empty_commit: got gate=%b done=%b mode=%b credit=%b expected 0/0/1/1", bus.lce_req_gate_o, bus.switch_done_o, bus.mode_o, bus.mem_cmd_credit_o); end
        bus.mode_req_i = 1'b0;
        tick(); tick(); tick();
        total++; if (bus.mode_o !== 1'b0 || bus.switch_busy_o !== 1'b0)
            begin bad++; $display("[TB] FAIL empty_switch_back: got mode=%b busy=%b expected 0/0", bus.mode_o, bus.switch_busy_o); end
    endtask

    task automatic test_drain_traffic();
        bus.mem_cmd_v_i = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.outstanding_o !== 3'd3 || bus.mem_cmd_credit_o !== 1'b1)
            begin bad++; $display("[TB] FAIL traffic_fill: got cnt=%0d credit=%b expected 3/1", bus.outstanding_o, bus.mem_cmd_credit_o); end
        bus.mem_cmd_v_i = 1'b0;
        bus.mode_req_i  = 1'b1;
        tick();
        total++; if (bus.mem_cmd_credit_o !== 1'b0 || bus.lce_req_gate_o !== 1'b1 || bus.outstanding_o !== 3'd3)
            begin bad++; $display("[TB] FAIL traffic_drain_enter: got credit=%b gate=%b cnt=%0d expected 0/1/3", bus.mem_cmd_credit_o, bus.lce_req_gate_o, bus.outstanding_o); end
        tick(); tick();
        total++; if (bus.switch_busy_o !== 1'b1 || bus.switch_done_o !== 1'b0 || bus.mode_o !== 1'b0)
            begin bad++; $display("[TB] FAIL traffic_drain_hold: got busy=%b done=%b mode=%b expected 1/0/0", bus.switch_busy_o, bus.switch_done_o, bus.mode_o); end
        bus.mem_resp_v_i = 1'b1; bus.mem_resp_yumi_i = 1'b1;
        tick();
        bus.mem_resp_v_i = 1'b0; bus.mem_resp_yumi_i = 1'b0;
        tick();
        bus.mem_resp_v_i = 1'b1; bus.mem_resp_yumi_i = 1'b1;
        tick();
        bus.mem_resp_v_i = 1'b0; bus.mem_resp_yumi_i = 1'b0;
        total++; if (bus.outstanding_o !== 3'd1 || bus.switch_done_o !== 1'b0)
            begin bad++; $display("[TB] FAIL traffic_partial: got cnt=%0d done=%b expected 1/0", bus.outstanding_o, bus.switch_done_o); end
        tick(); tick();
        bus.mem_resp_v_i = 1'b1; bus.mem_resp_yumi_i = 1'b1;
        tick();
        bus.mem_resp_v_i = 1'b0; bus.mem_resp_yumi_i = 1'b0;
        total++; if (bus.outstanding_o !== 3'd0 || bus.switch_done_o !== 1'b1 || bus.mode_o !== 1'b0)
            begin bad++; $display("[TB] FAIL traffic_switch: got cnt=%0d done=%b mode=%b expected 0/1/0", bus.outstanding_o, bus.switch_done_o, bus.mode_o); end
        tick();
        total++; if (bus.mode_o !== 1'b1 || bus.switch_done_o !== 1'b0 || bus.lce_req_gate_o !== 1'b0)
            begin bad++; $display("[TB] FAIL traffic_commit: got mode=%b done=%b gate=%b expected 1/0/0", bus.mode_o, bus.switch_done_o, bus.lce_req_gate_o); end
    endtask

    task automatic test_credit_limit();
        bus.mem_cmd_v_i = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.outstanding_o !== 3'd3 || bus.mem_cmd_credit_o !== 1'b1)
            begin bad++; $display("[TB] FAIL credit_at3: got cnt=%0d credit=%b expected 3/1", bus.outstanding_o, bus.mem_cmd_credit_o); end
        tick();
        total++; if (bus.outstanding_o !== 3'd4 || bus.mem_cmd_credit_o !== 1'b0 || bus.error_o !== 1'b0)
            begin bad++; $display("[TB] FAIL credit_at4: got cnt=%0d credit=%b err=%b expected 4/0/0", bus.outstanding_o, bus.mem_cmd_credit_o, bus.error_o); end
        bus.mem_resp_v_i = 1'b1; bus.mem_resp_yumi_i = 1'b1;
        tick();
        total++; if (bus.outstanding_o !== 3'd4 || bus.error_o !== 1'b0)
            begin bad++; $display("[TB] FAIL credit_incdec: got cnt=%0d err=%b expected 4/0", bus.outstanding_o, bus.error_o); end
        bus.mem_resp_v_i = 1'b0; bus.mem_resp_yumi_i = 1'b0;
        tick();
        total++; if (bus.outstanding_o !== 3'd4 || bus.error_o !== 1'b1)
            begin bad++; $display("[TB] FAIL credit_overflow: got cnt=%0d err=%b expected 4/1", bus.outstanding_o, bus.error_o); end
        bus.mem_cmd_v_i = 1'b0;
        bus.mem_resp_v_i = 1'b1; bus.mem_resp_yumi_i = 1'b1;
        tick(); tick(); tick(); tick();
        bus.mem_resp_v_i = 1'b0; bus.mem_resp_yumi_i = 1'b0;
        total++; if (bus.outstanding_o !== 3'd0 || bus.mem_cmd_credit_o !== 1'b1 || bus.error_o !== 1'b1)
            begin bad++; $display("[TB] FAIL credit_sticky: got cnt=%0d credit=%b err=%b expected 0/1/1", bus.outstanding_o, bus.mem_cmd_credit_o, bus.error_o); end
        bus.mode_req_i = 1'b0;
        reset_n_i = 1'b0;
        tick(); tick();
        reset_n_i = 1'b1;
        total++; if (bus.error_o !== 1'b0 || bus.mode_o !== 1'b0)
            begin bad++; $display("[TB] FAIL credit_reset_clear: got err=%b mode=%b expected 0/0", bus.error_o, bus.mode_o); end
    endtask

    task automatic test_revert();
        int done_seen;
        done_seen = 0;
        bus.mem_cmd_v_i = 1'b1;
        tick(); tick();
        bus.mem_cmd_v_i = 1'b0;
        bus.mode_req_i  = 1'b1;
        tick();
        bus.mode_req_i  = 1'b0;
        bus.mem_cmd_v_i = 1'b1;
        tick();
        bus.mem_cmd_v_i = 1'b0;
        total++; if (bus.outstanding_o !== 3'd3 || bus.error_o !== 1'b0 || bus.switch_busy_o !== 1'b1)
            begin bad++; $display("[TB] FAIL revert_inc_in_drain: got cnt=%0d err=%b busy=%b expected 3/0/1", bus.outstanding_o, bus.error_o, bus.switch_busy_o); end
        bus.mem_resp_v_i = 1'b1; bus.mem_resp_yumi_i = 1'b1;
        tick(); tick();
        total++; if (bus.outstanding_o !== 3'd1 || bus.switch_done_o !== 1'b0)
            begin bad++; $display("[TB] FAIL revert_draining: got cnt=%0d done=%b expected 1/0", bus.outstanding_o, bus.switch_done_o); end
        tick();
        bus.mem_resp_v_i = 1'b0; bus.mem_resp_yumi_i = 1'b0;
        if (bus.switch_done_o === 1'b1) done_seen++;
        total++; if (bus.switch_done_o !== 1'b1 || bus.mode_o !== 1'b0)
            begin bad++; $display("[TB] FAIL revert_first_switch: got done=%b mode=%b expected 1/0", bus.switch_done_o, bus.mode_o); end
        tick();
        total++; if (bus.mode_o !== 1'b1 || bus.switch_busy_o !== 1'b0)
            begin bad++; $display("[TB] FAIL revert_first_commit: got mode=%b busy=%b expected 1/0", bus.mode_o, bus.switch_busy_o); end
        tick();
        total++; if (bus.switch_busy_o !== 1'b1 || bus.switch_done_o !== 1'b0)
            begin bad++; $display("[TB] FAIL revert_second_drain: got busy=%b done=%b expected 1/0", bus.switch_busy_o, bus.switch_done_o); end
        tick();
        if (bus.switch_done_o === 1'b1) done_seen++;
        tick();
        total++; if (bus.mode_o !== 1'b0 || bus.switch_done_o !== 1'b0)
            begin bad++; $display("[TB] FAIL revert_second_commit: got mode=%b done=%b expected 0/0", bus.mode_o, bus.switch_done_o); end
        total++; if (done_seen !== 2)
            begin bad++; $display("[TB] FAIL revert_done_pulses: got %0d expected 2", done_seen); end
    endtask

    task automatic test_async_reset();
        bus.mode_req_i = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.mode_o !== 1'b1)
            begin bad++; $display("[TB] FAIL areset_pre_mode: got %b expected 1", bus.mode_o); end
        bus.mem_cmd_v_i = 1'b1;
        tick(); tick();
        bus.mem_cmd_v_i = 1'b0;
        bus.mode_req_i  = 1'b0;
        tick();
        total++; if (bus.switch_busy_o !== 1'b1 || bus.outstanding_o !== 3'd2)
            begin bad++; $display("[TB] FAIL areset_in_drain: got busy=%b cnt=%0d expected 1/2", bus.switch_busy_o, bus.outstanding_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        total++; if (bus.mode_o !== 1'b0 || bus.outstanding_o !== 3'd0 || bus.lce_req_gate_o !== 1'b0 || bus.error_o !== 1'b0 || bus.switch_done_o !== 1'b0 || bus.mem_cmd_credit_o !== 1'b1)
            begin bad++; $display("[TB] FAIL areset_immediate: got mode=%b cnt=%0d gate=%b err=%b done=%b credit=%b expected 0/0/0/0/0/1", bus.mode_o, bus.outstanding_o, bus.lce_req_gate_o, bus.error_o, bus.switch_done_o, bus.mem_cmd_credit_o); end
        tick();
        reset_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.switch_done_o !== 1'b0 || bus.mode_o !== 1'b0)
                begin bad++; $display("[TB] FAIL areset_after%0d: got done=%b mode=%b expected 0/0", i, bus.switch_done_o, bus.mode_o); end
        end
    endtask

    // Runs every scenario in order, then reports.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_empty_switch();
        test_drain_traffic();
        test_credit_limit();
        test_revert();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
